// File: rtl/point_marker_overlay_if.sv
// Point-detection result bus plus VGA scan position and marker outputs.
// The detector/scan side uses the master modport, the overlay block the slave.
interface point_marker_overlay_if;
    logic       i_finished;
    logic [9:0] i_centerX;
    logic [8:0] i_centerY;
    logic [2:0] i_mask;
    logic       i_clear;
    logic       i_frame_start;
    logic [9:0] i_x;
    logic [9:0] i_y;
    logic       o_marker;
    logic [1:0] o_marker_id;
    logic [2:0] o_num_points;
    logic       o_all_found;
    logic [2:0] o_last_mask;

    modport master (
        output i_finished, i_centerX, i_centerY, i_mask, i_clear, i_frame_start, i_x, i_y,
        input  o_marker, o_marker_id, o_num_points, o_all_found, o_last_mask
    );

    modport slave (
        input  i_finished, i_centerX, i_centerY, i_mask, i_clear, i_frame_start, i_x, i_y,
        output o_marker, o_marker_id, o_num_points, o_all_found, o_last_mask
    );
endinterface

// File: rtl/point_marker_overlay.sv
// Point marker overlay: captures up to MAX_NUM detected point centres into a
// shadow bank, commits them to a display bank at each frame start, and flags
// scan positions that fall on a displayed marker (1-cycle registered latency).
// Optional macro CROSSHAIR_EN: draw a crosshair instead of a filled box.
module point_marker_overlay #(
    parameter int MAX_NUM   = 4,
    parameter int HALF_SIZE = 4,
    parameter int DUP_DIST  = 2
) (
    input logic clk,
    input logic rst,
    point_marker_overlay_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, COLLECT, FULL} state_t;

    localparam logic [2:0]         MAX_CNT  = 3'(MAX_NUM);
    localparam logic signed [10:0] HALF_LIM = 11'(HALF_SIZE);
    localparam logic signed [10:0] DUP_LIM  = 11'(DUP_DIST);

    // 11-bit signed difference magnitude, so coordinates near 0 never wrap.
    function automatic logic signed [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? -d : d;
    endfunction

    function automatic logic near(input logic [9:0] a, input logic [9:0] b,
                                  input logic signed [10:0] lim);
        return abs_diff(a, b) <= lim;
    endfunction

    state_t             state;
    logic [2:0]         num;
    logic               all_found;
    logic [2:0]         last_mask;
    logic [2:0]         num_inc;

    logic [MAX_NUM-1:0] sh_vld;
    logic [9:0]         sh_cx [MAX_NUM];
    logic [8:0]         sh_cy [MAX_NUM];
    logic [MAX_NUM-1:0] dp_vld;
    logic [9:0]         dp_cx [MAX_NUM];
    logic [8:0]         dp_cy [MAX_NUM];

    logic               dup;
    logic               accept;
    logic               hit_any;
    logic [1:0]         hit_id;
    logic               marker_p1;
    logic [1:0]         marker_id_p1;

    assign num_inc = num + 3'd1;

    // Duplicate detection against every valid shadow slot.
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < MAX_NUM; k++) begin
            if (sh_vld[k] && near(bus.i_centerX, sh_cx[k], DUP_LIM) &&
                near({1'b0, bus.i_centerY}, {1'b0, sh_cy[k]}, DUP_LIM))
                dup = 1'b1;
        end
    end

    assign accept = bus.i_finished && (state != FULL) && !dup && !bus.i_clear;

    // Capture FSM: point count, full flag and last accepted mask.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            num       <= 3'd0;
            all_found <= 1'b0;
            last_mask <= 3'd0;
        end else if (bus.i_clear) begin
            state     <= EMPTY;
            num       <= 3'd0;
            all_found <= 1'b0;
        end else if (accept) begin
            num       <= num_inc;
            last_mask <= bus.i_mask;
            if (num_inc == MAX_CNT) begin
                state     <= FULL;
                all_found <= 1'b1;
            end else begin
                state     <= COLLECT;
            end
        end
    end

    // Shadow bank: an accepted point lands in the slot indexed by the current count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_vld <= '0;
            for (int k = 0; k < MAX_NUM; k++) begin
                sh_cx[k] <= 10'd0;
                sh_cy[k] <= 9'd0;
            end
        end else if (bus.i_clear) begin
            sh_vld <= '0;
        end else if (accept) begin
            for (int k = 0; k < MAX_NUM; k++) begin
                if (num == 3'(k)) begin
                    sh_vld[k] <= 1'b1;
                    sh_cx[k]  <= bus.i_centerX;
                    sh_cy[k]  <= bus.i_centerY;
                end
            end
        end
    end

    // Display bank: takes the pre-update shadow contents at frame start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dp_vld <= '0;
            for (int k = 0; k < MAX_NUM; k++) begin
                dp_cx[k] <= 10'd0;
                dp_cy[k] <= 9'd0;
            end
        end else if (bus.i_frame_start) begin
            dp_vld <= sh_vld;
            for (int k = 0; k < MAX_NUM; k++) begin
                dp_cx[k] <= sh_cx[k];
                dp_cy[k] <= sh_cy[k];
            end
        end
    end

    // Marker hit test; scanning from the top slot down lets the lowest slot win.
    always_comb begin
        hit_any = 1'b0;
        hit_id  = 2'd0;
        for (int k = MAX_NUM - 1; k >= 0; k--) begin
`ifdef CROSSHAIR_EN
            if (dp_vld[k] &&
                (((bus.i_x == dp_cx[k]) && near(bus.i_y, {1'b0, dp_cy[k]}, HALF_LIM)) ||
                 ((bus.i_y == {1'b0, dp_cy[k]}) && near(bus.i_x, dp_cx[k], HALF_LIM)))) begin
`else
            if (dp_vld[k] && near(bus.i_x, dp_cx[k], HALF_LIM) &&
                near(bus.i_y, {1'b0, dp_cy[k]}, HALF_LIM)) begin
`endif
                hit_any = 1'b1;
                hit_id  = 2'(k);
            end
        end
    end

    // Stage p1: registered marker flag and slot id.
    always_ff @(posedge clk) begin
        if (!rst) begin
            marker_p1    <= 1'b0;
            marker_id_p1 <= 2'd0;
        end else begin
            marker_p1    <= hit_any;
            marker_id_p1 <= hit_id;
        end
    end

    assign bus.o_marker     = marker_p1;
    assign bus.o_marker_id  = marker_id_p1;
    assign bus.o_num_points = num;
    assign bus.o_all_found  = all_found;
    assign bus.o_last_mask  = last_mask;
endmodule
